// File: rtl/fmac_special_stage_if.sv
// ---------------------------------------------------------------------------
// fmac_special_stage_if
//   Bundles the operand bus, the valid/ready handshakes on both sides and the
//   result bus of the FMAC special-case stage.
//   Signal groups:
//     upstream   : Flush_SI, Valid_SI, Ready_SO, operand fields and class flags
//     downstream : Valid_SO, Ready_SI, product sign/exponent, exponent
//                  difference, mantissa/sign pass-through, special result,
//                  invalid flag, stall counter
//   Modports:
//     slave  : the stage itself
//     master : the environment driving operands and taking results
// ---------------------------------------------------------------------------
interface fmac_special_stage_if #(
    parameter int C_EXP  = 8,
    parameter int C_MANT = 23,
    parameter int C_OP   = 32
);
    logic                     Flush_SI;
    logic                     Valid_SI;
    logic                     Ready_SO;
    logic                     Sign_a_DI, Sign_b_DI, Sign_c_DI;
    logic [C_EXP-1:0]         Exp_a_DI, Exp_b_DI, Exp_c_DI;
    logic [C_MANT:0]          Mant_a_DI, Mant_b_DI, Mant_c_DI;
    logic                     Inf_a_SI, Inf_b_SI, Inf_c_SI;
    logic                     Zero_a_SI, Zero_b_SI, Zero_c_SI;
    logic                     NaN_a_SI, NaN_b_SI, NaN_c_SI;

    logic                     Valid_SO;
    logic                     Ready_SI;
    logic                     Sign_prod_DO;
    logic signed [C_EXP+1:0]  Exp_prod_DO;
    logic signed [C_EXP+1:0]  Exp_diff_DO;
    logic [C_MANT:0]          Mant_a_DO, Mant_b_DO, Mant_c_DO;
    logic                     Sign_c_DO;
    logic                     Special_SO;
    logic [C_OP-1:0]          Result_special_DO;
    logic                     NV_SO;
    logic [15:0]              Stall_cnt_DO;

    modport slave (
        input  Flush_SI, Valid_SI,
        input  Sign_a_DI, Sign_b_DI, Sign_c_DI,
        input  Exp_a_DI, Exp_b_DI, Exp_c_DI,
        input  Mant_a_DI, Mant_b_DI, Mant_c_DI,
        input  Inf_a_SI, Inf_b_SI, Inf_c_SI,
        input  Zero_a_SI, Zero_b_SI, Zero_c_SI,
        input  NaN_a_SI, NaN_b_SI, NaN_c_SI,
        input  Ready_SI,
        output Ready_SO, Valid_SO,
        output Sign_prod_DO, Exp_prod_DO, Exp_diff_DO,
        output Mant_a_DO, Mant_b_DO, Mant_c_DO, Sign_c_DO,
        output Special_SO, Result_special_DO, NV_SO, Stall_cnt_DO
    );

    modport master (
        output Flush_SI, Valid_SI,
        output Sign_a_DI, Sign_b_DI, Sign_c_DI,
        output Exp_a_DI, Exp_b_DI, Exp_c_DI,
        output Mant_a_DI, Mant_b_DI, Mant_c_DI,
        output Inf_a_SI, Inf_b_SI, Inf_c_SI,
        output Zero_a_SI, Zero_b_SI, Zero_c_SI,
        output NaN_a_SI, NaN_b_SI, NaN_c_SI,
        output Ready_SI,
        input  Ready_SO, Valid_SO,
        input  Sign_prod_DO, Exp_prod_DO, Exp_diff_DO,
        input  Mant_a_DO, Mant_b_DO, Mant_c_DO, Sign_c_DO,
        input  Special_SO, Result_special_DO, NV_SO, Stall_cnt_DO
    );
endinterface

// File: rtl/fmac_special_stage.sv
// ---------------------------------------------------------------------------
// fmac_special_stage
//   Register stage behind the FMAC operand preprocessor. Computes the biased
//   product exponent (Exp_a+Exp_b-C_BIAS) and the product-to-addend exponent
//   difference, resolves NaN/Inf/zero results with invalid-operation
//   detection, and registers everything behind a valid/ready handshake
//   (latency 1, no bubble on simultaneous drain and load).
//   Ports:
//     Clk_CI  : clock
//     Rst_RBI : asynchronous active-low reset
//     bus     : fmac_special_stage_if.slave (operands, handshakes, results)
//   Optional feature:
//     FMAC_STALL_CNT_EN : when defined, a saturating 16-bit counter of stalled
//                         cycles drives Stall_cnt_DO; otherwise it reads 0.
// ---------------------------------------------------------------------------
module fmac_special_stage #(
    parameter int              C_EXP  = 8,
    parameter int              C_MANT = 23,
    parameter int              C_OP   = 32,
    parameter int              C_BIAS = 127,
    parameter logic [C_OP-1:0] C_QNAN = 32'h7FC00000
) (
    input logic                 Clk_CI,
    input logic                 Rst_RBI,
    fmac_special_stage_if.slave bus
);
    localparam int EW = C_EXP + 2;
    localparam logic signed [EW-1:0] BIAS_S   = EW'(C_BIAS);
    localparam logic [C_EXP-1:0]     EXP_ONES = '1;

    function automatic logic signed [EW-1:0] ext_exp(input logic [C_EXP-1:0] e);
        return signed'({2'b00, e});
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                 vld_p1;
    logic                 sign_prod_p0;
    logic signed [EW-1:0] exp_prod_p0, exp_diff_p0;
    logic                 special_p0, nv_p0;
    logic [C_OP-1:0]      result_p0;
    logic                 any_nan, snan, inf_times_zero, prod_inf, prod_zero;
    logic [C_EXP-1:0]     c_exp_field;
    logic                 load, drain;

    assign bus.Ready_SO = ~vld_p1 | bus.Ready_SI;
    assign load  = bus.Valid_SI & bus.Ready_SO & ~bus.Flush_SI;
    assign drain = vld_p1 & bus.Ready_SI;

    // ---- stage p0: exponent arithmetic and special-case resolution ----
    assign sign_prod_p0 = bus.Sign_a_DI ^ bus.Sign_b_DI;
    assign exp_prod_p0  = ext_exp(bus.Exp_a_DI) + ext_exp(bus.Exp_b_DI) - BIAS_S;
    assign exp_diff_p0  = exp_prod_p0 - ext_exp(bus.Exp_c_DI);

    assign any_nan = bus.NaN_a_SI | bus.NaN_b_SI | bus.NaN_c_SI;
    // A NaN is signalling when the top stored mantissa bit is clear.
    assign snan = (bus.NaN_a_SI & ~bus.Mant_a_DI[C_MANT-1])
                | (bus.NaN_b_SI & ~bus.Mant_b_DI[C_MANT-1])
                | (bus.NaN_c_SI & ~bus.Mant_c_DI[C_MANT-1]);
    assign inf_times_zero = (bus.Inf_a_SI & bus.Zero_b_SI) | (bus.Zero_a_SI & bus.Inf_b_SI);
    assign prod_inf  = bus.Inf_a_SI | bus.Inf_b_SI;
    assign prod_zero = bus.Zero_a_SI | bus.Zero_b_SI;
    // Denormal exponents arrive forced to 1; a clear hidden bit restores field 0.
    assign c_exp_field = bus.Mant_c_DI[C_MANT] ? bus.Exp_c_DI : '0;

    always_comb begin
        special_p0 = 1'b1;
        nv_p0      = 1'b0;
        result_p0  = '0;
        if (any_nan) begin
            result_p0 = C_QNAN;
            nv_p0     = snan;
        end else if (inf_times_zero) begin
            result_p0 = C_QNAN;
            nv_p0     = 1'b1;
        end else if (prod_inf && bus.Inf_c_SI && (sign_prod_p0 != bus.Sign_c_DI)) begin
            result_p0 = C_QNAN;
            nv_p0     = 1'b1;
        end else if (prod_inf) begin
            result_p0 = {sign_prod_p0, EXP_ONES, {C_MANT{1'b0}}};
        end else if (bus.Inf_c_SI) begin
            result_p0 = {bus.Sign_c_DI, EXP_ONES, {C_MANT{1'b0}}};
        end else if (prod_zero && bus.Zero_c_SI) begin
            result_p0 = {sign_prod_p0 & bus.Sign_c_DI, {(C_OP-1){1'b0}}};
        end else if (prod_zero) begin
            result_p0 = {bus.Sign_c_DI, c_exp_field, bus.Mant_c_DI[C_MANT-1:0]};
        end else begin
            special_p0 = 1'b0;
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            vld_p1 <= 1'b0;
        end else if (bus.Flush_SI) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1 <= 1'b1;
        end else if (drain) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            bus.Sign_prod_DO      <= 1'b0;
            bus.Exp_prod_DO       <= '0;
            bus.Exp_diff_DO       <= '0;
            bus.Mant_a_DO         <= '0;
            bus.Mant_b_DO         <= '0;
            bus.Mant_c_DO         <= '0;
            bus.Sign_c_DO         <= 1'b0;
            bus.Special_SO        <= 1'b0;
            bus.Result_special_DO <= '0;
            bus.NV_SO             <= 1'b0;
        end else if (load) begin
            bus.Sign_prod_DO      <= sign_prod_p0;
            bus.Exp_prod_DO       <= exp_prod_p0;
            bus.Exp_diff_DO       <= exp_diff_p0;
            bus.Mant_a_DO         <= bus.Mant_a_DI;
            bus.Mant_b_DO         <= bus.Mant_b_DI;
            bus.Mant_c_DO         <= bus.Mant_c_DI;
            bus.Sign_c_DO         <= bus.Sign_c_DI;
            bus.Special_SO        <= special_p0;
            bus.Result_special_DO <= result_p0;
            bus.NV_SO             <= nv_p0;
        end
    end

    assign bus.Valid_SO = vld_p1;

`ifdef FMAC_STALL_CNT_EN
    logic [15:0] stall_cnt_p1;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            stall_cnt_p1 <= '0;
        end else if (vld_p1 && !bus.Ready_SI) begin
            stall_cnt_p1 <= sat_inc16(stall_cnt_p1);
        end
    end

    assign bus.Stall_cnt_DO = stall_cnt_p1;
`else
    assign bus.Stall_cnt_DO = sat_inc16(16'hFFFF) & 16'h0000;
`endif
endmodule

// File: tb/tb_fmac_special_stage.sv
// ---------------------------------------------------------------------------
// tb_fmac_special_stage
//   Directed bench for fmac_special_stage: reset state, exponent arithmetic
//   including range extremes, every special-case class, stall/drain/flush
//   handshaking and reset during a stall.
// ---------------------------------------------------------------------------
module tb_fmac_special_stage;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    fmac_special_stage_if ifc ();

    fmac_special_stage dut (
        .Clk_CI  (clk),
        .Rst_RBI (rst_n),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] f_exp(input logic [31:0] f);
        return (f[30:23] == 8'd0) ? 8'd1 : f[30:23];
    endfunction
    function automatic logic [23:0] f_mant(input logic [31:0] f);
        return {f[30:23] != 8'd0, f[22:0]};
    endfunction
    function automatic logic f_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    endfunction
    function automatic logic f_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction
    function automatic logic f_zero(input logic [31:0] f);
        return f[30:0] == 31'd0;
    endfunction

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        ifc.Sign_a_DI = a[31]; ifc.Exp_a_DI = f_exp(a); ifc.Mant_a_DI = f_mant(a);
        ifc.Inf_a_SI = f_inf(a); ifc.Zero_a_SI = f_zero(a); ifc.NaN_a_SI = f_nan(a);
        ifc.Sign_b_DI = b[31]; ifc.Exp_b_DI = f_exp(b); ifc.Mant_b_DI = f_mant(b);
        ifc.Inf_b_SI = f_inf(b); ifc.Zero_b_SI = f_zero(b); ifc.NaN_b_SI = f_nan(b);
        ifc.Sign_c_DI = c[31]; ifc.Exp_c_DI = f_exp(c); ifc.Mant_c_DI = f_mant(c);
        ifc.Inf_c_SI = f_inf(c); ifc.Zero_c_SI = f_zero(c); ifc.NaN_c_SI = f_nan(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One valid transaction through a ready downstream; checks the special outputs.
    task automatic run_special(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic sp, input logic [31:0] res,
                               input logic nv);
        set_ops(a, b, c);
        ifc.Valid_SI = 1'b1;
        tick();
        chk({tag, "_valid"}, 32'(ifc.Valid_SO), 32'd1);
        chk({tag, "_special"}, 32'(ifc.Special_SO), 32'(sp));
        chk({tag, "_result"}, ifc.Result_special_DO, res);
        chk({tag, "_nv"}, 32'(ifc.NV_SO), 32'(nv));
    endtask

    initial begin
        logic [31:0] exp_stall;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ifc.Flush_SI = 1'b0;
        ifc.Valid_SI = 1'b0;
        ifc.Ready_SI = 1'b1;
        set_ops(32'h0, 32'h0, 32'h0);

        // Reset state
        #12;
        chk("rst_valid", 32'(ifc.Valid_SO), 32'd0);
        chk("rst_special", 32'(ifc.Special_SO), 32'd0);
        chk("rst_nv", 32'(ifc.NV_SO), 32'd0);
        chk("rst_result", ifc.Result_special_DO, 32'd0);
        chk("rst_exp_prod", 32'(ifc.Exp_prod_DO), 32'd0);
        chk("rst_ready", 32'(ifc.Ready_SO), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1.0 * 2.0 + 3.0
        set_ops(32'h3F800000, 32'h40000000, 32'h40400000);
        ifc.Valid_SI = 1'b1;
        tick();
        chk("n1_valid", 32'(ifc.Valid_SO), 32'd1);
        chk("n1_exp_prod", 32'(ifc.Exp_prod_DO), 32'd128);
        chk("n1_exp_diff", 32'(ifc.Exp_diff_DO), 32'd0);
        chk("n1_special", 32'(ifc.Special_SO), 32'd0);
        chk("n1_sign_prod", 32'(ifc.Sign_prod_DO), 32'd0);
        chk("n1_mant_a", 32'(ifc.Mant_a_DO), 32'h800000);
        chk("n1_mant_c", 32'(ifc.Mant_c_DO), 32'hC00000);

        // Exponent extremes: min product exponent / min difference
        set_ops(32'h00800000, 32'h80800000, 32'h7F000000);
        tick();
        chk("lo_exp_prod", 32'(ifc.Exp_prod_DO), -32'sd125);
        chk("lo_exp_diff", 32'(ifc.Exp_diff_DO), -32'sd379);
        chk("lo_sign_prod", 32'(ifc.Sign_prod_DO), 32'd1);
        chk("lo_special", 32'(ifc.Special_SO), 32'd0);
        // Max product exponent / max difference (c denormal, exponent forced to 1)
        set_ops(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000001);
        tick();
        chk("hi_exp_prod", 32'(ifc.Exp_prod_DO), 32'd381);
        chk("hi_exp_diff", 32'(ifc.Exp_diff_DO), 32'd380);
        chk("hi_sign_c", 32'(ifc.Sign_c_DO), 32'd0);

        // Special cases
        run_special("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b1);
        run_special("inf_m_inf", 32'h7F800000, 32'h3F800000, 32'hFF800000, 1'b1, 32'h7FC00000, 1'b1);
        run_special("inf_p_inf", 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 32'h7F800000, 1'b0);
        run_special("prod_ninf", 32'hFF800000, 32'h3F800000, 32'h3F800000, 1'b1, 32'hFF800000, 1'b0);
        run_special("c_ninf", 32'h3F800000, 32'h3F800000, 32'hFF800000, 1'b1, 32'hFF800000, 1'b0);
        run_special("snan_a", 32'h7FA00000, 32'h3F800000, 32'h00000000, 1'b1, 32'h7FC00000, 1'b1);
        run_special("qnan_a", 32'h7FC00001, 32'h3F800000, 32'h00000000, 1'b1, 32'h7FC00000, 1'b0);
        run_special("snan_c", 32'h3F800000, 32'h3F800000, 32'hFF800001, 1'b1, 32'h7FC00000, 1'b1);
        run_special("nz_nz", 32'h80000000, 32'h3F800000, 32'h80000000, 1'b1, 32'h80000000, 1'b0);
        run_special("nz_pz", 32'h80000000, 32'h3F800000, 32'h00000000, 1'b1, 32'h00000000, 1'b0);
        run_special("z_denc", 32'h80000000, 32'h3F800000, 32'h00000001, 1'b1, 32'h00000001, 1'b0);
        run_special("z_normc", 32'h00000000, 32'h40000000, 32'hC0400000, 1'b1, 32'hC0400000, 1'b0);
        run_special("normal", 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 32'h00000000, 1'b0);

        // Drain with no new input
        ifc.Valid_SI = 1'b0;
        tick();
        chk("drain_valid", 32'(ifc.Valid_SO), 32'd0);

        // Stall: load A, downstream blocked 3 cycles while B waits, then release
        ifc.Ready_SI = 1'b0;
        set_ops(32'h3F800000, 32'h40000000, 32'h40400000);
        ifc.Valid_SI = 1'b1;
        tick();
        chk("st_load_valid", 32'(ifc.Valid_SO), 32'd1);
        chk("st_ready_low", 32'(ifc.Ready_SO), 32'd0);
        set_ops(32'h40000000, 32'h40000000, 32'h3F800000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_hold_exp", 32'(ifc.Exp_prod_DO), 32'd128);
            chk("st_hold_valid", 32'(ifc.Valid_SO), 32'd1);
            chk("st_hold_ready", 32'(ifc.Ready_SO), 32'd0);
        end
        ifc.Ready_SI = 1'b1;
        #1;
        chk("st_ready_pass", 32'(ifc.Ready_SO), 32'd1);
        tick();
        chk("st_b_valid", 32'(ifc.Valid_SO), 32'd1);
        chk("st_b_exp_prod", 32'(ifc.Exp_prod_DO), 32'd129);
        chk("st_b_exp_diff", 32'(ifc.Exp_diff_DO), 32'd2);
        ifc.Valid_SI = 1'b0;
        tick();
        chk("st_drained", 32'(ifc.Valid_SO), 32'd0);
`ifdef FMAC_STALL_CNT_EN
        exp_stall = 32'd3;
`else
        exp_stall = 32'd0;
`endif
        chk("stall_cnt", 32'(ifc.Stall_cnt_DO), exp_stall);

        // Flush during stall beats a concurrent load
        ifc.Ready_SI = 1'b0;
        set_ops(32'h3F800000, 32'h40000000, 32'h40400000);
        ifc.Valid_SI = 1'b1;
        tick();
        chk("fl_loaded", 32'(ifc.Valid_SO), 32'd1);
        ifc.Flush_SI = 1'b1;
        #1;
        chk("fl_ready_same", 32'(ifc.Ready_SO), 32'd0);
        tick();
        chk("fl_valid", 32'(ifc.Valid_SO), 32'd0);
        ifc.Flush_SI = 1'b0;
        ifc.Valid_SI = 1'b0;

        // Reset during stall drops the entry immediately
        set_ops(32'h7F800000, 32'h00000000, 32'h3F800000);
        ifc.Valid_SI = 1'b1;
        tick();
        chk("rs_loaded", 32'(ifc.Special_SO), 32'd1);
        ifc.Valid_SI = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 32'(ifc.Valid_SO), 32'd0);
        chk("rs_special", 32'(ifc.Special_SO), 32'd0);
        chk("rs_result", ifc.Result_special_DO, 32'd0);
        chk("rs_nv", 32'(ifc.NV_SO), 32'd0);
        chk("rs_stall_cnt", 32'(ifc.Stall_cnt_DO), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
